// File: rtl/o_table_loader_if.sv
// o_reg bus between the table loader (master) and o_table_mem (slave).
//   tab_init          : 1-cycle LSB-region clear request
//   o_reg_sel/o_reg_wr: access strobe and direction (1 = write)
//   o_reg_op_addr     : 9-bit table address
//   o_reg_wr_data     : write byte
//   table_mem_rd_data : read byte, valid RD_LAT cycles after the issue cycle
//   table_mem_rd_ok   : read acknowledge, expected one cycle after issue
interface o_table_loader_if;
  logic       tab_init;
  logic       o_reg_sel;
  logic       o_reg_wr;
  logic [8:0] o_reg_op_addr;
  logic [7:0] o_reg_wr_data;
  logic [7:0] table_mem_rd_data;
  logic       table_mem_rd_ok;

  modport master (
    output tab_init, o_reg_sel, o_reg_wr, o_reg_op_addr, o_reg_wr_data,
    input  table_mem_rd_data, table_mem_rd_ok
  );

  modport slave (
    input  tab_init, o_reg_sel, o_reg_wr, o_reg_op_addr, o_reg_wr_data,
    output table_mem_rd_data, table_mem_rd_ok
  );
endinterface

// File: rtl/o_table_loader.sv
// Host-side sequencer for the o_reg port of o_table_mem (pix_clk domain).
// Load streams RAM_BYTES + LSB_BYTES host bytes into the table with a running
// 16-bit checksum; verify reads every location back and sums it.
// Ports:
//   pix_clk, rst_n             : clock, async active-low reset
//   load_start, verify_start   : 1-cycle start pulses (load wins if both)
//   abort                      : level, returns to idle without done
//   exp_csum                   : expected checksum, latched on start
//   host_data/valid/ready      : load byte stream handshake
//   busy, done, csum           : status, completion pulse, running checksum
//   csum_err, proto_err        : sticky error flags, cleared on start
//   tbl                        : o_reg bus to o_table_mem (master side)
module o_table_loader #(
  parameter int unsigned RAM_BYTES = 256,
  parameter int unsigned LSB_BYTES = 32,
  parameter int unsigned RD_LAT    = 2
) (
  input  logic        pix_clk,
  input  logic        rst_n,
  input  logic        load_start,
  input  logic        verify_start,
  input  logic        abort,
  input  logic [15:0] exp_csum,
  input  logic [7:0]  host_data,
  input  logic        host_valid,
  output logic        host_ready,
  output logic        busy,
  output logic        done,
  output logic [15:0] csum,
  output logic        csum_err,
  output logic        proto_err,
  o_table_loader_if.master tbl
);

  localparam int unsigned TOTAL = RAM_BYTES + LSB_BYTES;
  localparam int unsigned CNT_W = 9;
  localparam int unsigned LAT_W = $clog2(RD_LAT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_WR, S_RD_ISSUE, S_RD_WAIT, S_FIN
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [15:0]      r_exp;
  logic [LAT_W-1:0] r_lat;
  logic             r_host_ready;
  logic             r_busy;
  logic             r_done;
  logic [15:0]      r_csum;
  logic             r_csum_err;
  logic             r_proto_err;
  logic             r_tab_init;
  logic             r_sel;
  logic             r_wr;
  logic [8:0]       r_addr;
  logic [7:0]       r_wdata;

  logic             w_accept;
  logic             w_last_wr;
  logic [CNT_W-1:0] w_cnt_inc;

  // Byte index to table address: RAM region first, then the LSB region at 0x100.
  function automatic logic [8:0] f_map(input logic [CNT_W-1:0] c);
    if (c < CNT_W'(RAM_BYTES)) f_map = {1'b0, c[7:0]};
    else                       f_map = 9'h100 + 9'(c - CNT_W'(RAM_BYTES));
  endfunction

  assign w_accept  = host_valid & r_host_ready;
  assign w_last_wr = (r_cnt == CNT_W'(TOTAL - 1));
  assign w_cnt_inc = r_cnt + CNT_W'(1);

  // Sequencer; every output is a register updated here.
  always_ff @(posedge pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_exp        <= '0;
      r_lat        <= '0;
      r_host_ready <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_csum       <= '0;
      r_csum_err   <= 1'b0;
      r_proto_err  <= 1'b0;
      r_tab_init   <= 1'b0;
      r_sel        <= 1'b0;
      r_wr         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
    end else begin
      r_done     <= 1'b0;
      r_tab_init <= 1'b0;
      if (r_state != S_IDLE && abort) begin
        // Partial checksum and partial table are left as they are.
        r_state      <= S_IDLE;
        r_sel        <= 1'b0;
        r_host_ready <= 1'b0;
        r_busy       <= 1'b0;
        r_lat        <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (load_start || verify_start) begin
              r_csum      <= '0;
              r_csum_err  <= 1'b0;
              r_proto_err <= 1'b0;
              r_cnt       <= '0;
              r_exp       <= exp_csum;
              r_busy      <= 1'b1;
              if (load_start) begin
                r_state    <= S_INIT;
                r_tab_init <= 1'b1;
              end else begin
                r_state <= S_RD_ISSUE;
                r_sel   <= 1'b1;
                r_wr    <= 1'b0;
                r_addr  <= f_map('0);
              end
            end
          end
          S_INIT: begin
            r_state      <= S_WR;
            r_host_ready <= 1'b1;
          end
          S_WR: begin
            // A write strobe only follows an accepted byte; gaps leave sel low.
            r_sel <= w_accept;
            if (w_accept) begin
              r_wr    <= 1'b1;
              r_addr  <= f_map(r_cnt);
              r_wdata <= host_data;
              r_csum  <= r_csum + {8'h00, host_data};
              r_cnt   <= w_cnt_inc;
              if (w_last_wr) begin
                r_host_ready <= 1'b0;
                r_state      <= S_FIN;
              end
            end
          end
          S_RD_ISSUE: begin
            r_sel   <= 1'b0;
            r_lat   <= LAT_W'(1);
            r_state <= S_RD_WAIT;
          end
          S_RD_WAIT: begin
            // r_lat is the cycle offset from the issue cycle.
            if (r_lat == LAT_W'(1) && !tbl.table_mem_rd_ok) r_proto_err <= 1'b1;
            if (r_lat == LAT_W'(RD_LAT)) begin
              r_csum <= r_csum + {8'h00, tbl.table_mem_rd_data};
              r_cnt  <= w_cnt_inc;
              r_lat  <= '0;
              if (w_cnt_inc < CNT_W'(TOTAL)) begin
                r_state <= S_RD_ISSUE;
                r_sel   <= 1'b1;
                r_addr  <= f_map(w_cnt_inc);
              end else begin
                r_state <= S_FIN;
              end
            end else begin
              r_lat <= r_lat + LAT_W'(1);
            end
          end
          S_FIN: begin
            r_csum_err <= (r_csum != r_exp);
            r_done     <= 1'b1;
            r_busy     <= 1'b0;
            r_sel      <= 1'b0;
            r_state    <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign host_ready        = r_host_ready;
  assign busy              = r_busy;
  assign done              = r_done;
  assign csum              = r_csum;
  assign csum_err          = r_csum_err;
  assign proto_err         = r_proto_err;
  assign tbl.tab_init      = r_tab_init;
  assign tbl.o_reg_sel     = r_sel;
  assign tbl.o_reg_wr      = r_wr;
  assign tbl.o_reg_op_addr = r_addr;
  assign tbl.o_reg_wr_data = r_wdata;

endmodule

// File: tb/tb_o_table_loader.sv
// Self-checking bench for o_table_loader: table-driven load/verify runs against
// a behavioural o_table_mem plus hand-written abort and reset sequences.
module tb_o_table_loader;
  localparam int RAM_BYTES = 256;
  localparam int LSB_BYTES = 32;
  localparam int RD_LAT    = 2;
  localparam int TOTAL     = RAM_BYTES + LSB_BYTES;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_start = 1'b0, verify_start = 1'b0, abort = 1'b0;
  logic [15:0] exp_csum = '0;
  logic [7:0]  host_data = '0;
  logic        host_valid = 1'b0;
  logic        host_ready, busy, done, csum_err, proto_err;
  logic [15:0] csum;

  o_table_loader_if bus();

  o_table_loader #(.RAM_BYTES(RAM_BYTES), .LSB_BYTES(LSB_BYTES), .RD_LAT(RD_LAT)) dut (
    .pix_clk(clk), .rst_n(rst_n), .load_start(load_start), .verify_start(verify_start),
    .abort(abort), .exp_csum(exp_csum), .host_data(host_data), .host_valid(host_valid),
    .host_ready(host_ready), .busy(busy), .done(done), .csum(csum),
    .csum_err(csum_err), .proto_err(proto_err), .tbl(bus)
  );

  always #5 clk = ~clk;

  // Behavioural o_table_mem plus bus logging.
  logic [7:0] mem [512];
  logic       rd_ok_r = 1'b0;
  logic [7:0] rd_d1 = '0, rd_data_r = '0;
  int cyc = 0, tinit_cnt = 0, done_cnt = 0, rd_total = 0, withhold_abs = -1;
  int wr_addr_q[$], wr_data_q[$], rd_addr_q[$], rd_cyc_q[$];

  assign bus.table_mem_rd_ok   = rd_ok_r;
  assign bus.table_mem_rd_data = rd_data_r;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (bus.tab_init) begin
      tinit_cnt <= tinit_cnt + 1;
      for (int i = RAM_BYTES; i < TOTAL; i++) mem[i] <= 8'h00;
    end
    rd_ok_r <= 1'b0;
    if (bus.o_reg_sel && bus.o_reg_wr) begin
      mem[bus.o_reg_op_addr] <= bus.o_reg_wr_data;
      wr_addr_q.push_back(int'(bus.o_reg_op_addr));
      wr_data_q.push_back(int'(bus.o_reg_wr_data));
    end
    if (bus.o_reg_sel && !bus.o_reg_wr) begin
      rd_addr_q.push_back(int'(bus.o_reg_op_addr));
      rd_cyc_q.push_back(cyc);
      rd_ok_r  <= (rd_total != withhold_abs);
      rd_total <= rd_total + 1;
    end
    rd_d1     <= mem[bus.o_reg_op_addr];
    rd_data_r <= rd_d1;
  end

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  function automatic int exp_addr(input int i);
    return (i < RAM_BYTES) ? i : 'h100 + (i - RAM_BYTES);
  endfunction

  typedef struct {
    string       name;
    bit          is_verify;
    int          pat;        // 0: i^5A, 1: all FF, 2: random
    int          gap_pct;
    int          exp_adj;    // offset applied to the true sum for exp_csum
    int          withhold;   // read index without ack, -1 none
    bit          use_const;
    logic [15:0] csum_const;
    bit          exp_cerr;
    bit          exp_perr;
    int          exp_lat;    // start-to-done cycles, -1 unchecked
  } vec_t;

  function automatic vec_t mk(input string nm, input bit iv, input int pat, input int gap,
                              input int adj, input int wh, input bit uc, input logic [15:0] cc,
                              input bit ce, input bit pe, input int lat);
    vec_t v;
    v.name = nm; v.is_verify = iv; v.pat = pat; v.gap_pct = gap; v.exp_adj = adj;
    v.withhold = wh; v.use_const = uc; v.csum_const = cc; v.exp_cerr = ce;
    v.exp_perr = pe; v.exp_lat = lat;
    return v;
  endfunction

  logic [7:0] bytes_a [TOTAL];
  logic [7:0] tbl_img [TOTAL];

  function automatic int sum_bytes(input int n, input bit img);
    int s = 0;
    for (int i = 0; i < n; i++) s += img ? int'(tbl_img[i]) : int'(bytes_a[i]);
    return s % 65536;
  endfunction

  task automatic fill_bytes(input int pat);
    for (int i = 0; i < TOTAL; i++) begin
      logic [8:0] iv;
      iv = 9'(i);
      case (pat)
        0:       bytes_a[i] = iv[7:0] ^ 8'h5A;
        1:       bytes_a[i] = 8'hFF;
        default: bytes_a[i] = 8'($urandom);
      endcase
    end
  endtask

  task automatic run_op(input vec_t v, input bit both, input bit inject);
    int ws, rs, ts, msum, idx, bad, start_cyc, done_cyc, nw, nr;
    bit got, is_load;
    logic [15:0] want;
    is_load = !v.is_verify || both;
    if (is_load) begin fill_bytes(v.pat); msum = sum_bytes(TOTAL, 1'b0); end
    else msum = sum_bytes(TOTAL, 1'b1);
    want = v.use_const ? v.csum_const : 16'(msum);
    ws = wr_addr_q.size(); rs = rd_addr_q.size(); ts = tinit_cnt;
    withhold_abs = (v.withhold >= 0) ? rd_total + v.withhold : -1;
    @(negedge clk);
    exp_csum     = 16'(msum + v.exp_adj);
    load_start   = is_load;
    verify_start = v.is_verify || both;
    start_cyc    = cyc + 1;
    idx = 0; got = 1'b0; done_cyc = 0;
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      load_start = 1'b0; verify_start = 1'b0;
      if (inject && n == 20) load_start = 1'b1;
      if (n == 10) chk({v.name, "_busy"}, 32'(busy), 32'd1);
      if (done) begin got = 1'b1; done_cyc = cyc; break; end
      host_valid = 1'b0;
      if (is_load && idx < TOTAL && (v.gap_pct == 0 || $urandom_range(99) >= v.gap_pct)) begin
        host_valid = 1'b1;
        host_data  = bytes_a[idx];
        if (host_ready) idx++;
      end
    end
    host_valid = 1'b0;
    withhold_abs = -1;
    chk({v.name, "_done_seen"}, 32'(got), 32'd1);
    if (v.exp_lat >= 0) chk({v.name, "_latency"}, 32'(done_cyc - start_cyc), 32'(v.exp_lat));
    chk({v.name, "_csum"}, 32'(csum), 32'(want));
    chk({v.name, "_csum_err"}, 32'(csum_err), 32'(v.exp_cerr));
    chk({v.name, "_proto_err"}, 32'(proto_err), 32'(v.exp_perr));
    @(negedge clk);
    chk({v.name, "_done_1cyc"}, 32'(done), 32'd0);
    chk({v.name, "_idle"}, 32'(busy), 32'd0);
    nw = wr_addr_q.size() - ws;
    nr = rd_addr_q.size() - rs;
    bad = 0;
    if (is_load) begin
      chk({v.name, "_nwrites"}, 32'(nw), 32'(TOTAL));
      for (int k = 0; k < nw && k < TOTAL; k++)
        if (wr_addr_q[ws+k] != exp_addr(k) || wr_data_q[ws+k] != int'(bytes_a[k])) bad++;
      chk({v.name, "_wr_seq_bad"}, 32'(bad), 32'd0);
      chk({v.name, "_tab_init"}, 32'(tinit_cnt - ts), 32'd1);
      chk({v.name, "_nreads"}, 32'(nr), 32'd0);
      for (int k = 0; k < TOTAL; k++) tbl_img[k] = bytes_a[k];
    end else begin
      chk({v.name, "_nreads"}, 32'(nr), 32'(TOTAL));
      for (int k = 0; k < nr && k < TOTAL; k++) begin
        if (rd_addr_q[rs+k] != exp_addr(k)) bad++;
        if (k > 0 && rd_cyc_q[rs+k] - rd_cyc_q[rs+k-1] != 1 + RD_LAT) bad++;
      end
      chk({v.name, "_rd_seq_bad"}, 32'(bad), 32'd0);
      chk({v.name, "_nwrites"}, 32'(nw), 32'd0);
      chk({v.name, "_tab_init"}, 32'(tinit_cnt - ts), 32'd0);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_csum"}, 32'(csum), 32'd0);
    chk({tag, "_csum_err"}, 32'(csum_err), 32'd0);
    chk({tag, "_proto_err"}, 32'(proto_err), 32'd0);
    chk({tag, "_host_ready"}, 32'(host_ready), 32'd0);
    chk({tag, "_tab_init"}, 32'(bus.tab_init), 32'd0);
    chk({tag, "_sel"}, 32'(bus.o_reg_sel), 32'd0);
    chk({tag, "_wr"}, 32'(bus.o_reg_wr), 32'd0);
    chk({tag, "_addr"}, 32'(bus.o_reg_op_addr), 32'd0);
    chk({tag, "_wdata"}, 32'(bus.o_reg_wr_data), 32'd0);
  endtask

  vec_t vecs[7];

  initial begin
    int idx, dc0, ws;
    bit reached;
    vecs[0] = mk("load_5a",      1'b0, 0,  0,  0, -1, 1'b1, 16'h8970, 1'b0, 1'b0, TOTAL + 2);
    vecs[1] = mk("load_ff_gaps", 1'b0, 1, 30,  0, -1, 1'b1, 16'h1EE0, 1'b0, 1'b0, -1);
    vecs[2] = mk("load_rand",    1'b0, 2, 25,  0, -1, 1'b0, 16'h0000, 1'b0, 1'b0, -1);
    vecs[3] = mk("load_5a_bad",  1'b0, 0,  0,  1, -1, 1'b1, 16'h8970, 1'b1, 1'b0, TOTAL + 2);
    vecs[4] = mk("vfy_ok",       1'b1, 0,  0,  0, -1, 1'b1, 16'h8970, 1'b0, 1'b0, TOTAL * (1 + RD_LAT) + 1);
    vecs[5] = mk("vfy_bad",      1'b1, 0,  0, -1, -1, 1'b1, 16'h8970, 1'b1, 1'b0, TOTAL * (1 + RD_LAT) + 1);
    vecs[6] = mk("vfy_noack5",   1'b1, 0,  0,  0,  5, 1'b1, 16'h8970, 1'b0, 1'b1, TOTAL * (1 + RD_LAT) + 1);

    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    for (int r = 0; r < 7; r++) run_op(vecs[r], 1'b0, 1'b0);

    // Abort after 100 accepted bytes of a load.
    fill_bytes(0);
    ws = wr_addr_q.size();
    @(negedge clk);
    exp_csum = 16'h0; load_start = 1'b1;
    idx = 0; reached = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      load_start = 1'b0;
      if (idx == 100) begin reached = 1'b1; break; end
      host_valid = 1'b1; host_data = bytes_a[idx];
      if (host_ready) idx++;
    end
    chk("abort_reach100", 32'(reached), 32'd1);
    host_valid = 1'b0; abort = 1'b1;
    dc0 = done_cnt;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_host_ready", 32'(host_ready), 32'd0);
    chk("abort_sel", 32'(bus.o_reg_sel), 32'd0);
    repeat (5) @(negedge clk);
    chk("abort_no_done", 32'(done_cnt - dc0), 32'd0);
    chk("abort_csum_partial", 32'(csum), 32'(sum_bytes(100, 1'b0)));
    chk("abort_nwrites", 32'(wr_addr_q.size() - ws), 32'd100);

    // Both starts together: load runs from address 000 again.
    run_op(vecs[0], 1'b1, 1'b0);

    // Reset in the middle of a verify, then a clean verify with a start while busy.
    @(negedge clk);
    exp_csum = 16'h8970; verify_start = 1'b1;
    @(negedge clk);
    verify_start = 1'b0;
    repeat (50) @(negedge clk);
    chk("pre_reset_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run_op(vecs[4], 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
